// File: rtl/half_subtractor_unit.sv
// half_subtractor_unit
// Array of independent registered half-subtractor slices computing A - B
// with no borrow-in. Results appear one clock after a valid input and are
// qualified by out_valid.
// Optional feature macro: HSUB_BORROW_CNT_EN enables a saturating counter of
// valid cycles that produced any borrow. Without the macro, borrow_cnt is
// tied to zero and no counter logic is built.

module half_subtractor_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  output logic [WIDTH-1:0] outD,
  output logic [WIDTH-1:0] outB,
  output logic [CNT_W-1:0] borrow_cnt
);

  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] borrow_d;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic             valid_q;

  // Per-slice difference and borrow; slices never interact
  always_comb begin
    diff_d   = inA ^ inB;
    borrow_d = ~inA & inB;
  end

  // Result register: only loads on valid input so stale or X operands are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign outD      = diff_q;
  assign outB      = borrow_q;

`ifdef HSUB_BORROW_CNT_EN
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: bump on a valid cycle with any borrow, stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|borrow_d) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Borrow-event counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`else
  assign borrow_cnt = '0;
`endif

endmodule

// File: tb/tb_half_subtractor_unit.sv
// Scoreboard testbench for half_subtractor_unit (WIDTH=4, CNT_W=2).
// The driver pushes the modelled result of each valid input into a queue;
// a negedge monitor pops and compares whenever out_valid is seen, and checks
// that outputs hold while out_valid is low.
module tb_half_subtractor_unit;
  localparam int WIDTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] b;
    int               cyc;
    int               cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             out_valid;
  logic [WIDTH-1:0] outD;
  logic [WIDTH-1:0] outB;
  logic [CNT_W-1:0] borrow_cnt;

  exp_t expQ[$];
  int   checks;
  int   errors;
  int   cycleCnt;
  int   modelCnt;
  logic [WIDTH-1:0] heldD;
  logic [WIDTH-1:0] heldB;
  int   heldCnt;

  half_subtractor_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inA(inA), .inB(inB),
    .out_valid(out_valid), .outD(outD), .outB(outB), .borrow_cnt(borrow_cnt)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to verify one-cycle latency
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  // Reference: each slice is the integer subtraction a - b of two bits;
  // a negative result means a borrow, and the difference bit is the result mod 2
  function automatic void refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   output logic [WIDTH-1:0] d, output logic [WIDTH-1:0] bo);
    for (int i = 0; i < WIDTH; i++) begin
      int r;
      r = (a[i] ? 1 : 0) - (b[i] ? 1 : 0);
      bo[i] = (r < 0);
      d[i]  = ((r + 2) % 2) == 1;
    end
  endfunction

  // Drive one cycle of input; a valid input's result is queued for the monitor
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    if (v) begin
      inA = a;
      inB = b;
      refModel(a, b, e.d, e.b);
`ifdef HSUB_BORROW_CNT_EN
      if (e.b != '0 && modelCnt < CNT_MAX) modelCnt++;
`endif
      e.cyc = cycleCnt + 1;
      e.cnt = modelCnt;
      expQ.push_back(e);
    end else begin
      inA = 'x;
      inB = 'x;
    end
  endtask

  // Monitor: compare presented results against the scoreboard, and check hold otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("latency", cycleCnt, e.cyc);
          checkOutput("outD", int'(outD), int'(e.d));
          checkOutput("outB", int'(outB), int'(e.b));
          checkOutput("borrow_cnt", int'(borrow_cnt), e.cnt);
          heldD   = e.d;
          heldB   = e.b;
          heldCnt = e.cnt;
        end
      end else begin
        checkOutput("out_valid_known", int'(out_valid === 1'b0), 1);
        checkOutput("hold_outD", int'(outD), int'(heldD));
        checkOutput("hold_outB", int'(outB), int'(heldB));
        checkOutput("hold_borrow_cnt", int'(borrow_cnt), heldCnt);
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_outD"}, int'(outD), 0);
    checkOutput({tag, "_outB"}, int'(outB), 0);
    checkOutput({tag, "_borrow_cnt"}, int'(borrow_cnt), 0);
  endtask

  task automatic clearModel();
    expQ.delete();
    heldD    = '0;
    heldB    = '0;
    heldCnt  = 0;
    modelCnt = 0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cycleCnt = 0;
    clearModel();

    // Reset held with a borrowing input present: outputs must stay cleared
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inA      = '0;
    inB      = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetState("reset_hold");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Every slice sees the same bit pair: 00, 01, 10, 11
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    applyStimulus(1'b1, 4'b1111, 4'b1111);

    // Mixed pattern: 0101 - 0011 per slice
    applyStimulus(1'b1, 4'b0101, 4'b0011);

    // Single valid then a three-cycle gap with X operands
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0);

    // Borrow-heavy run drives the counter to saturation, then no-borrow cycles
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0000, 4'b1111);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 4'b1111, 4'b0000);
    applyStimulus(1'b0, '0, '0);

    // Asynchronous reset between edges while a result is being presented
    applyStimulus(1'b1, 4'b0010, 4'b1011);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_out_valid", int'(out_valid), 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    checkResetState("async_reset");
    clearModel();
    @(negedge clk);
    checkResetState("async_reset_hold");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    clearModel();

    // Randomized traffic with random valid gaps
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom));
    end
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
